// File: rtl/gtech_join5_sync.sv
`default_nettype none
// ============================================================================
//  Module      : gtech_join5_sync
//  Description : Five-lane handshake join stage. Each lane deposits one token
//                (valid/ready transfer) into its own holding register. When
//                all five lanes hold a token, the stage presents them as a
//                single joined beat downstream. The "all lanes held" term is
//                the 5-input AND of the per-lane held flags.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DW       data width per lane
//    TIMEOUT  cycles a partial set may wait before being discarded
//             (present only when JOIN5_TIMEOUT_EN is defined)
//    CW       timeout counter width, TIMEOUT < 2**CW
//             (present only when JOIN5_TIMEOUT_EN is defined)
//  Ports
//    clk          in   1     rising-edge clock
//    rst_n        in   1     asynchronous active-low reset
//    i_in_valid   in   5     per-lane valid, bit i = lane i
//    o_in_ready   out  5     per-lane ready (driven from registered state)
//    i_in_data    in   5*DW  lane i at [i*DW +: DW]
//    o_out_valid  out  1     joined beat available
//    i_out_ready  in   1     consumer accepts beat
//    o_out_data   out  5*DW  joined data, same lane packing as i_in_data
//    o_err        out  1     one-cycle pulse: partial set discarded on timeout
//  Configuration macro
//    JOIN5_TIMEOUT_EN  enables the partial-set timeout counter and o_err.
//                      Undefined: o_err is tied low, partial sets wait forever.
// ============================================================================
module gtech_join5_sync #(
  parameter int DW = 8
`ifdef JOIN5_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      i_in_valid,
  output logic [4:0]      o_in_ready,
  input  logic [5*DW-1:0] i_in_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [5*DW-1:0] o_out_data,
  output logic            o_err
);

  localparam logic [0:0] c_COLLECT = 1'b0;
  localparam logic [0:0] c_OUTPUT  = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_next_state;
  logic [4:0]    r_held;
  logic [4:0]    w_xfer;
  logic [4:0]    w_cap;
  logic [4:0]    w_held_or_xfer;
  logic          w_all_held;
  logic          w_timeout;
  logic [DW-1:0] r_data [5];

  // Transfers use the registered ready, so there is no combinational path
  // from i_in_valid / i_out_ready to o_in_ready.
  assign w_xfer         = i_in_valid & o_in_ready;
  // A transfer in the edge that completes the set counts straight away,
  // which is what gives one-cycle latency and a 2-cycle beat period.
  assign w_held_or_xfer = r_held | w_xfer;
  assign w_all_held     = &w_held_or_xfer;
  // Data captured on a timeout cycle would belong to a discarded set.
  assign w_cap          = w_xfer & ~{5{w_timeout}};

`ifdef JOIN5_TIMEOUT_EN
  localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  assign w_timeout = (r_state == c_COLLECT) && (|r_held) && (r_cnt == c_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_timeout) begin
      r_cnt <= '0;
    end else if (w_next_state == c_OUTPUT) begin
      r_cnt <= '0;
    end else if ((r_state == c_COLLECT) && (|r_held) && !(&r_held)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_COLLECT: begin
        if (!w_timeout && w_all_held) begin
          w_next_state = c_OUTPUT;
        end
      end
      c_OUTPUT: begin
        if (i_out_ready) begin
          w_next_state = c_COLLECT;
        end
      end
      default: w_next_state = c_COLLECT;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_out_valid = (r_state == c_OUTPUT);
    o_in_ready  = (r_state == c_COLLECT) ? ~r_held : 5'b00000;
    o_err       = w_timeout;
  end

  // --------------------------------------------------------------------------
  // Per-lane held flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= 5'b00000;
    end else if (r_state == c_COLLECT) begin
      r_held <= w_timeout ? 5'b00000 : w_held_or_xfer;
    end else if (i_out_ready) begin
      r_held <= 5'b00000;
    end
  end

  // --------------------------------------------------------------------------
  // Per-lane data registers
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 5; g++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data[g] <= '0;
      end else if (w_cap[g]) begin
        r_data[g] <= i_in_data[g*DW +: DW];
      end
    end

    assign o_out_data[g*DW +: DW] = r_data[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_gtech_join5_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gtech_join5_sync
//  Description : Directed self-checking bench for gtech_join5_sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gtech_join5_sync;

  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [4:0]      i_in_valid;
  logic [4:0]      o_in_ready;
  logic [5*DW-1:0] i_in_data;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [5*DW-1:0] o_out_data;
  logic            o_err;

  int vec;
  int miss;

`ifdef JOIN5_TIMEOUT_EN
  gtech_join5_sync #(.DW(DW), .TIMEOUT(4), .CW(8)) dut (
`else
  gtech_join5_sync #(.DW(DW)) dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_in_valid  = 5'h00;
    i_in_data   = '0;
    i_out_ready = 1'b0;
    rst_n       = 1'b0;
    #1;
    vec++;
    if (o_out_valid !== 1'b0 || o_err !== 1'b0) begin
      miss++;
      $display("FAIL reset_outputs: valid=%b err=%b required valid=0 err=0", o_out_valid, o_err);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    vec++;
    if (o_in_ready !== 5'h1F || o_out_data !== 40'h0) begin
      miss++;
      $display("FAIL reset_ready: ready=%h data=%h required ready=1f data=0", o_in_ready, o_out_data);
    end
  endtask

  task automatic test_reset_mid_output();
    i_out_ready = 1'b0;
    i_in_valid  = 5'h1F;
    i_in_data   = 40'hCAFEBABE01;
    tick();
    i_in_valid = 5'h00;
    vec++;
    if (o_out_valid !== 1'b1) begin
      miss++;
      $display("FAIL mid_reset_setup: valid=%b required 1", o_out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if (o_out_valid !== 1'b0 || o_err !== 1'b0) begin
      miss++;
      $display("FAIL mid_reset_drop: valid=%b err=%b required valid=0 err=0", o_out_valid, o_err);
    end
    tick();
    rst_n = 1'b1;
    #1;
    vec++;
    if (o_in_ready !== 5'h1F || o_out_valid !== 1'b0) begin
      miss++;
      $display("FAIL mid_reset_release: ready=%h valid=%b required ready=1f valid=0", o_in_ready, o_out_valid);
    end
  endtask

  task automatic test_simultaneous();
    i_out_ready = 1'b1;
    i_in_valid  = 5'h1F;
    i_in_data   = 40'h5544332211;
    tick();
    i_in_valid = 5'h00;
    i_in_data  = 40'hFFFFFFFFFF;
    vec++;
    if (o_out_valid !== 1'b1 || o_out_data !== 40'h5544332211 || o_in_ready !== 5'h00) begin
      miss++;
      $display("FAIL simul_beat: valid=%b data=%h ready=%h required valid=1 data=5544332211 ready=00",
               o_out_valid, o_out_data, o_in_ready);
    end
    tick();
    vec++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 5'h1F) begin
      miss++;
      $display("FAIL simul_after: valid=%b ready=%h required valid=0 ready=1f", o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_staggered();
    logic [4:0]  exp_ready;
    logic [39:0] dat;
    i_out_ready = 1'b1;
    i_in_valid  = 5'h00;
    for (int i = 0; i < 5; i++) begin
      // Earlier lanes keep valid high with changed data: must not be re-captured.
      dat = 40'hEEEEEEEEEE;
      dat[i*8 +: 8] = 8'hA0 + 8'(i);
      i_in_data  = dat;
      i_in_valid = i_in_valid | (5'b00001 << i);
      tick();
      if (i < 4) begin
        exp_ready = ~((5'b00010 << i) - 5'b00001);
        vec++;
        if (o_in_ready !== exp_ready || o_out_valid !== 1'b0) begin
          miss++;
          $display("FAIL stagger_lane%0d: ready=%h valid=%b required ready=%h valid=0",
                   i, o_in_ready, o_out_valid, exp_ready);
        end
      end
    end
    i_in_valid = 5'h00;
    vec++;
    if (o_out_valid !== 1'b1 || o_out_data !== 40'hA4A3A2A1A0) begin
      miss++;
      $display("FAIL stagger_beat: valid=%b data=%h required valid=1 data=a4a3a2a1a0", o_out_valid, o_out_data);
    end
    tick();
    vec++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 5'h1F) begin
      miss++;
      $display("FAIL stagger_after: valid=%b ready=%h required valid=0 ready=1f", o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_backpressure();
    i_out_ready = 1'b0;
    i_in_valid  = 5'h1F;
    i_in_data   = 40'h0102030405;
    tick();
    for (int c = 0; c < 10; c++) begin
      i_in_data = {$urandom(), 8'($urandom())};
      vec++;
      if (o_out_valid !== 1'b1 || o_out_data !== 40'h0102030405 || o_in_ready !== 5'h00) begin
        miss++;
        $display("FAIL bp_hold_c%0d: valid=%b data=%h ready=%h required valid=1 data=0102030405 ready=00",
                 c, o_out_valid, o_out_data, o_in_ready);
      end
      tick();
    end
    vec++;
    if (o_out_valid !== 1'b1 || o_out_data !== 40'h0102030405) begin
      miss++;
      $display("FAIL bp_final_hold: valid=%b data=%h required valid=1 data=0102030405", o_out_valid, o_out_data);
    end
    i_in_valid  = 5'h00;
    i_out_ready = 1'b1;
    tick();
    vec++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 5'h1F) begin
      miss++;
      $display("FAIL bp_release: valid=%b ready=%h required valid=0 ready=1f", o_out_valid, o_in_ready);
    end
  endtask

  task automatic test_throughput();
    int beats;
    beats       = 0;
    i_out_ready = 1'b1;
    i_in_valid  = 5'h1F;
    i_in_data   = 40'h123456789A;
    for (int k = 1; k <= 10; k++) begin
      tick();
      vec++;
      if (o_out_valid !== 1'((k % 2) == 1)) begin
        miss++;
        $display("FAIL tput_cycle%0d: valid=%b required %0d", k, o_out_valid, k % 2);
      end
      if (o_out_valid === 1'b1 && i_out_ready === 1'b1) beats++;
    end
    i_in_valid = 5'h00;
    vec++;
    if (beats != 5) begin
      miss++;
      $display("FAIL tput_beats: beats=%0d required 5", beats);
    end
    tick();
  endtask

`ifdef JOIN5_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    i_out_ready = 1'b1;
    i_in_valid  = 5'h03;
    i_in_data   = 40'h0000007766;
    tick();
    i_in_valid = 5'h00;
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (o_err !== 1'b0) begin
        miss++;
        $display("FAIL timeout_early%0d: err=%b required 0", k, o_err);
      end
      tick();
    end
    vec++;
    if (o_err !== 1'b1 || o_in_ready !== 5'h1C) begin
      miss++;
      $display("FAIL timeout_pulse: err=%b ready=%h required err=1 ready=1c", o_err, o_in_ready);
    end
    tick();
    vec++;
    if (o_err !== 1'b0 || o_in_ready !== 5'h1F || o_out_valid !== 1'b0) begin
      miss++;
      $display("FAIL timeout_after: err=%b ready=%h valid=%b required err=0 ready=1f valid=0",
               o_err, o_in_ready, o_out_valid);
    end
  endtask
`else
  task automatic test_timeout();
    int errs;
    errs = 0;
    do_reset();
    i_out_ready = 1'b1;
    i_in_valid  = 5'h03;
    i_in_data   = 40'h0000007766;
    tick();
    i_in_valid = 5'h00;
    for (int k = 0; k < 300; k++) begin
      if (o_err !== 1'b0) errs++;
      tick();
    end
    vec++;
    if (errs != 0) begin
      miss++;
      $display("FAIL no_timeout_err: err cycles=%0d required 0", errs);
    end
    vec++;
    if (o_in_ready !== 5'h1C || o_out_valid !== 1'b0) begin
      miss++;
      $display("FAIL no_timeout_wait: ready=%h valid=%b required ready=1c valid=0", o_in_ready, o_out_valid);
    end
    do_reset();
  endtask
`endif

  initial begin
    vec  = 0;
    miss = 0;
    test_reset();
    test_simultaneous();
    test_staggered();
    test_backpressure();
    test_throughput();
    test_reset_mid_output();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
